// File: rtl/nand_page_read_capture.sv
// nand_page_read_capture
//   Read-data stage that runs after the NAND command/address latch sequencer
//   has issued the read command, the address cycles and the 0x30 confirm.
//   The stage waits tWB, then waits for R/B# to report ready (with a
//   timeout), then strobes RE# once per byte. Each byte is captured off the
//   shared IO bus into a single holding register and offered on a
//   valid/ready stream. The next RE# pulse is not started until the
//   consumer has taken the byte that is being held.
//
// Ports
//   clk, rst     system clock; asynchronous active-high reset
//   start        one-cycle request, accepted only while idle
//   num_bytes    number of bytes to read, latched when start is accepted
//   rb_n         NAND ready/busy# (asynchronous, low = busy)
//   io_in        NAND IO bus
//   re_n, ce_n   NAND read enable / chip enable, both active low
//   data_out     captured byte
//   data_valid   data_out holds a byte that has not been taken yet
//   data_ready   consumer takes the byte when this and data_valid are high
//   byte_idx     index of the byte on data_out, counting from 0
//   busy         high whenever the stage is not idle
//   done         one-cycle pulse at the end of an operation
//   timeout      sticky flag: R/B# stayed busy too long; cleared by start
module nand_page_read_capture #(
  parameter int CNT_W       = 12,
  parameter int TWB_CYC     = 4,
  parameter int RE_LOW_CYC  = 2,
  parameter int RE_HIGH_CYC = 2,
  parameter int TO_W        = 16,
  parameter int TO_CYC      = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic             rb_n,
  input  logic [7:0]       io_in,
  output logic             re_n,
  output logic             ce_n,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] byte_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  // One phase counter is shared by the tWB wait, the RE# low time and the
  // RE# high time; it only has to reach the largest of the three minus one.
  localparam int PH_MAX = (TWB_CYC > RE_LOW_CYC)
                          ? ((TWB_CYC > RE_HIGH_CYC) ? TWB_CYC : RE_HIGH_CYC)
                          : ((RE_LOW_CYC > RE_HIGH_CYC) ? RE_LOW_CYC : RE_HIGH_CYC);
  localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] TWB_LAST = PH_W'(TWB_CYC - 1);
  localparam logic [PH_W-1:0] LO_LAST  = PH_W'(RE_LOW_CYC - 1);
  localparam logic [PH_W-1:0] HI_LAST  = PH_W'(RE_HIGH_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TWB,
    S_WAIT_RDY,
    S_RE_LO,
    S_RE_HI,
    S_FIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PH_W-1:0]  phase_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] remaining;
  logic             rb_meta;
  logic             rbs;

  logic             accept;   // start taken this cycle
  logic             lo_last;  // final RE# low cycle: capture io_in
  logic             hi_met;   // minimum RE# high time satisfied
  logic             to_hit;   // R/B# wait has run out
  logic             xfer;     // byte handed to the consumer this cycle

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    lo_last    = 1'b0;
    to_hit     = 1'b0;
    xfer       = data_valid & data_ready;
    hi_met     = (phase_cnt == HI_LAST);
    re_n       = 1'b1;
    ce_n       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state)
      S_IDLE: begin
        ce_n = 1'b1;
        busy = 1'b0;
        if (start) begin
          accept     = 1'b1;
          state_next = S_TWB;
        end
      end
      S_TWB: begin
        if (phase_cnt == TWB_LAST) state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (rbs) begin
          state_next = (remaining != '0) ? S_RE_LO : S_FIN;
        end else if (to_cnt == TO_LAST) begin
          to_hit     = 1'b1;
          state_next = S_FIN;
        end
      end
      S_RE_LO: begin
        re_n = 1'b0;
        if (phase_cnt == LO_LAST) begin
          lo_last    = 1'b1;
          state_next = S_RE_HI;
        end
      end
      S_RE_HI: begin
        // Backpressure holds us here: the next RE# fall waits for the
        // holding register to be empty.
        if (hi_met && !data_valid) begin
          state_next = (remaining == CNT_W'(1)) ? S_FIN : S_RE_LO;
        end
      end
      S_FIN: begin
        ce_n       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register, counters and the byte holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      to_cnt     <= '0;
      remaining  <= '0;
      rb_meta    <= 1'b0;
      rbs        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      byte_idx   <= '0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      rb_meta <= rb_n;
      rbs     <= rb_meta;
      state   <= state_next;

      // Restart the phase count on every state change; the RE# high count
      // saturates once met so a long stall cannot wrap it.
      if (state_next != state) begin
        phase_cnt <= '0;
      end else if ((state == S_TWB) || (state == S_RE_LO) ||
                   ((state == S_RE_HI) && !hi_met)) begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      if (accept) begin
        remaining <= num_bytes;
        to_cnt    <= '0;
        timeout   <= 1'b0;
        byte_idx  <= '0;
      end

      if ((state == S_WAIT_RDY) && !rbs && !to_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (to_hit) begin
        timeout <= 1'b1;
      end

      if ((state == S_RE_HI) && (state_next != S_RE_HI)) begin
        remaining <= remaining - 1'b1;
      end

      // Capture and handoff never coincide: RE_LO is only entered with the
      // holding register empty.
      if (lo_last) begin
        data_out   <= io_in;
        data_valid <= 1'b1;
      end else if (xfer) begin
        data_valid <= 1'b0;
        byte_idx   <= byte_idx + 1'b1;
      end
    end
  end

endmodule
